// File: rtl/nn_acc_layer_sequencer.sv
// Avalon-MM master that streams weight and image vectors into the MAC accelerator,
// polls for the dot product, optionally applies ReLU and writes each neuron result back.
module nn_acc_layer_sequencer #(
    parameter int VECTOR_LEN   = 96,
    parameter int ADDR_WIDTH   = 32,
    parameter int NEURON_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [NEURON_WIDTH-1:0] num_neurons,
    input  logic [ADDR_WIDTH-1:0]   weight_base,
    input  logic [ADDR_WIDTH-1:0]   image_base,
    input  logic [ADDR_WIDTH-1:0]   result_base,
    input  logic                    relu_en,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [31:0]             mem_writedata,
    input  logic                    mem_waitrequest,
    input  logic [31:0]             mem_readdata,
    input  logic                    mem_readdatavalid,
    output logic [7:0]              acc_address,
    output logic                    acc_read,
    output logic                    acc_write,
    output logic [31:0]             acc_writedata,
    input  logic [31:0]             acc_readdata
);

    localparam int IW = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
    localparam logic [IW-1:0]         I_LAST     = IW'(VECTOR_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP  = ADDR_WIDTH'(4);
    localparam logic [7:0]            ACC_W_BASE = 8'h01;
    localparam logic [7:0]            ACC_I_BASE = 8'h61;
    localparam logic [7:0]            ACC_RESULT = 8'hC1;
    localparam logic [7:0]            ACC_STATUS = 8'hD9;

    typedef enum logic [3:0] {
        IDLE, FETCH_W, WAIT_W, PUSH_W, FETCH_I, WAIT_I, PUSH_I,
        POLL, POLL_WAIT, RD_RES, RD_WAIT, WR_RES, NEXT, FINISH
    } state_t;

    // Both negative values and -0.0 collapse to +0.0 when ReLU is enabled.
    function automatic logic [31:0] relu_clamp(input logic [31:0] v, input logic en);
        return (en && v[31]) ? 32'h0 : v;
    endfunction

    state_t                  state_q, state_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
    logic                    mem_read_q, mem_read_d;
    logic                    mem_write_q, mem_write_d;
    logic [31:0]             mem_writedata_q, mem_writedata_d;
    logic [7:0]              acc_address_q, acc_address_d;
    logic                    acc_read_q, acc_read_d;
    logic                    acc_write_q, acc_write_d;
    logic [31:0]             acc_writedata_q, acc_writedata_d;
    logic [IW-1:0]           i_q, i_d;
    logic [NEURON_WIDTH-1:0] n_q, n_d;
    logic [NEURON_WIDTH-1:0] num_q, num_d;
    logic [ADDR_WIDTH-1:0]   w_ptr_q, w_ptr_d;
    logic [ADDR_WIDTH-1:0]   i_ptr_q, i_ptr_d;
    logic [ADDR_WIDTH-1:0]   r_ptr_q, r_ptr_d;
    logic [ADDR_WIDTH-1:0]   img_base_q, img_base_d;
    logic                    relu_q, relu_d;
    logic [NEURON_WIDTH-1:0] n_inc;

    assign n_inc = n_q + NEURON_WIDTH'(1);

    // Weight vectors are contiguous across neurons, so a running pointer replaces
    // the n*VECTOR_LEN+i product; the image pointer rewinds for every neuron.
    always_comb begin
        state_d         = state_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        mem_address_d   = mem_address_q;
        mem_read_d      = mem_read_q;
        mem_write_d     = mem_write_q;
        mem_writedata_d = mem_writedata_q;
        acc_address_d   = acc_address_q;
        acc_read_d      = 1'b0;
        acc_write_d     = 1'b0;
        acc_writedata_d = acc_writedata_q;
        i_d             = i_q;
        n_d             = n_q;
        num_d           = num_q;
        w_ptr_d         = w_ptr_q;
        i_ptr_d         = i_ptr_q;
        r_ptr_d         = r_ptr_q;
        img_base_d      = img_base_q;
        relu_d          = relu_q;
        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start && !busy_q) begin
                    busy_d     = 1'b1;
                    n_d        = '0;
                    i_d        = '0;
                    num_d      = num_neurons;
                    w_ptr_d    = weight_base;
                    i_ptr_d    = image_base;
                    img_base_d = image_base;
                    r_ptr_d    = result_base;
                    relu_d     = relu_en;
                    if (num_neurons == '0) begin
                        state_d = FINISH;
                    end else begin
                        state_d       = FETCH_W;
                        mem_read_d    = 1'b1;
                        mem_address_d = weight_base;
                    end
                end
            end
            FETCH_W: begin
                if (!mem_waitrequest) begin
                    mem_read_d = 1'b0;
                    w_ptr_d    = w_ptr_q + WORD_STEP;
                    state_d    = WAIT_W;
                end
            end
            WAIT_W: begin
                if (mem_readdatavalid) begin
                    acc_write_d     = 1'b1;
                    acc_address_d   = ACC_W_BASE + 8'(i_q);
                    acc_writedata_d = mem_readdata;
                    state_d         = PUSH_W;
                end
            end
            PUSH_W: begin
                mem_read_d = 1'b1;
                if (i_q == I_LAST) begin
                    i_d           = '0;
                    mem_address_d = i_ptr_q;
                    state_d       = FETCH_I;
                end else begin
                    i_d           = i_q + IW'(1);
                    mem_address_d = w_ptr_q;
                    state_d       = FETCH_W;
                end
            end
            FETCH_I: begin
                if (!mem_waitrequest) begin
                    mem_read_d = 1'b0;
                    i_ptr_d    = i_ptr_q + WORD_STEP;
                    state_d    = WAIT_I;
                end
            end
            WAIT_I: begin
                if (mem_readdatavalid) begin
                    acc_write_d     = 1'b1;
                    acc_address_d   = ACC_I_BASE + 8'(i_q);
                    acc_writedata_d = mem_readdata;
                    state_d         = PUSH_I;
                end
            end
            PUSH_I: begin
                if (i_q == I_LAST) begin
                    i_d           = '0;
                    acc_read_d    = 1'b1;
                    acc_address_d = ACC_STATUS;
                    state_d       = POLL;
                end else begin
                    i_d           = i_q + IW'(1);
                    mem_read_d    = 1'b1;
                    mem_address_d = i_ptr_q;
                    state_d       = FETCH_I;
                end
            end
            POLL: state_d = POLL_WAIT;
            POLL_WAIT: begin
                acc_read_d = 1'b1;
                if (acc_readdata[0]) begin
                    acc_address_d = ACC_RESULT;
                    state_d       = RD_RES;
                end else begin
                    acc_address_d = ACC_STATUS;
                    state_d       = POLL;
                end
            end
            RD_RES: state_d = RD_WAIT;
            RD_WAIT: begin
                mem_write_d     = 1'b1;
                mem_address_d   = r_ptr_q;
                mem_writedata_d = relu_clamp(acc_readdata, relu_q);
                state_d         = WR_RES;
            end
            WR_RES: begin
                if (!mem_waitrequest) begin
                    mem_write_d = 1'b0;
                    r_ptr_d     = r_ptr_q + WORD_STEP;
                    state_d     = NEXT;
                end
            end
            NEXT: begin
                n_d = n_inc;
                if (n_inc == num_q) begin
                    state_d = FINISH;
                end else begin
                    i_d           = '0;
                    i_ptr_d       = img_base_q;
                    mem_read_d    = 1'b1;
                    mem_address_d = w_ptr_q;
                    state_d       = FETCH_W;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            mem_address_q   <= '0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_writedata_q <= '0;
            acc_address_q   <= '0;
            acc_read_q      <= 1'b0;
            acc_write_q     <= 1'b0;
            acc_writedata_q <= '0;
            i_q             <= '0;
            n_q             <= '0;
            num_q           <= '0;
            w_ptr_q         <= '0;
            i_ptr_q         <= '0;
            r_ptr_q         <= '0;
            img_base_q      <= '0;
            relu_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            mem_address_q   <= mem_address_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_writedata_q <= mem_writedata_d;
            acc_address_q   <= acc_address_d;
            acc_read_q      <= acc_read_d;
            acc_write_q     <= acc_write_d;
            acc_writedata_q <= acc_writedata_d;
            i_q             <= i_d;
            n_q             <= n_d;
            num_q           <= num_d;
            w_ptr_q         <= w_ptr_d;
            i_ptr_q         <= i_ptr_d;
            r_ptr_q         <= r_ptr_d;
            img_base_q      <= img_base_d;
            relu_q          <= relu_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign mem_address   = mem_address_q;
    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_writedata = mem_writedata_q;
    assign acc_address   = acc_address_q;
    assign acc_read      = acc_read_q;
    assign acc_write     = acc_write_q;
    assign acc_writedata = acc_writedata_q;

endmodule

// File: tb/tb_nn_acc_layer_sequencer.sv
// Bench for nn_acc_layer_sequencer: memory and accelerator models on the falling edge,
// scoreboard queues of expected reads, accelerator pushes and result writes.
module tb_nn_acc_layer_sequencer;

    localparam int VL      = 96;
    localparam int AW      = 32;
    localparam int NW      = 16;
    localparam int TIMEOUT = 8000;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [NW-1:0] num_neurons;
    logic [AW-1:0] weight_base, image_base, result_base;
    logic          relu_en;
    logic          busy, done;
    logic [AW-1:0] mem_address;
    logic          mem_read, mem_write;
    logic [31:0]   mem_writedata;
    logic          mem_waitrequest;
    logic [31:0]   mem_readdata;
    logic          mem_readdatavalid;
    logic [7:0]    acc_address;
    logic          acc_read, acc_write;
    logic [31:0]   acc_writedata;
    logic [31:0]   acc_readdata;

    nn_acc_layer_sequencer #(.VECTOR_LEN(VL), .ADDR_WIDTH(AW), .NEURON_WIDTH(NW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_neurons(num_neurons),
        .weight_base(weight_base), .image_base(image_base), .result_base(result_base),
        .relu_en(relu_en), .busy(busy), .done(done),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_waitrequest(mem_waitrequest),
        .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
        .acc_address(acc_address), .acc_read(acc_read), .acc_write(acc_write),
        .acc_writedata(acc_writedata), .acc_readdata(acc_readdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_rd_addr [$];
    logic [39:0] exp_acc_wr [$];
    logic [63:0] exp_mem_wr [$];
    logic [31:0] wv [0:3];
    logic [31:0] res_val [0:3];
    bit          stall_en;
    int          poll_hold;
    int          res_idx, poll_cnt, d9_cnt, c1_cnt, acc_wr_cnt, done_cnt;
    int          extra_cnt, strobe_viol, stall_viol, wait_run, rd_dly;
    bit          rd_pend, hold_flag;
    logic [31:0] rd_data, h_addr, h_wd, m_a;
    logic        h_rd, h_wr;
    logic [39:0] m_acc;
    logic [63:0] m_wr;

    // Inputs change on the falling edge; a request seen here with waitrequest low is
    // the one the DUT accepts on the next rising edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            mem_waitrequest   = 1'b0;
            mem_readdatavalid = 1'b0;
            rd_pend           = 1'b0;
            hold_flag         = 1'b0;
            wait_run          = 0;
        end else begin
            if (hold_flag && (mem_address !== h_addr || mem_read !== h_rd || mem_write !== h_wr ||
                              (h_wr && mem_writedata !== h_wd)))
                stall_viol++;
            mem_readdatavalid = 1'b0;
            if (rd_pend) begin
                if (rd_dly == 0) begin
                    mem_readdatavalid = 1'b1;
                    mem_readdata      = rd_data;
                    rd_pend           = 1'b0;
                end else begin
                    rd_dly--;
                end
            end else if (stall_en && !mem_read && $urandom_range(0, 7) == 0) begin
                mem_readdatavalid = 1'b1;
                mem_readdata      = 32'hBAD0BAD0;
            end
            if ((mem_read || mem_write) && stall_en && wait_run < 3 && $urandom_range(0, 1) == 1) begin
                mem_waitrequest = 1'b1;
                wait_run++;
            end else begin
                mem_waitrequest = 1'b0;
                wait_run        = 0;
            end
            if (mem_read && !mem_waitrequest) begin
                if (exp_rd_addr.size() == 0) extra_cnt++;
                else begin
                    m_a = exp_rd_addr.pop_front();
                    check("mem_rd_addr", mem_address, m_a);
                end
                rd_data = mem.exists(mem_address) ? mem[mem_address] : 32'hDEADBEEF;
                rd_pend = 1'b1;
                rd_dly  = stall_en ? $urandom_range(0, 3) : 0;
            end
            if (mem_write && !mem_waitrequest) begin
                if (exp_mem_wr.size() == 0) extra_cnt++;
                else begin
                    m_wr = exp_mem_wr.pop_front();
                    check("mem_wr_addr", mem_address, m_wr[63:32]);
                    check("mem_wr_data", mem_writedata, m_wr[31:0]);
                end
            end
            hold_flag = (mem_read || mem_write) && mem_waitrequest;
            h_addr = mem_address; h_rd = mem_read; h_wr = mem_write; h_wd = mem_writedata;

            if (acc_read && acc_write) strobe_viol++;
            if ((acc_read || acc_write) && (mem_read || mem_write)) strobe_viol++;
            if (acc_write) begin
                acc_wr_cnt++;
                if (exp_acc_wr.size() == 0) extra_cnt++;
                else begin
                    m_acc = exp_acc_wr.pop_front();
                    check("acc_wr_addr", acc_address, m_acc[39:32]);
                    check("acc_wr_data", acc_writedata, m_acc[31:0]);
                end
            end
            if (acc_read) begin
                if (acc_address == 8'hD9) begin
                    d9_cnt++;
                    acc_readdata = {31'd0, poll_cnt >= poll_hold};
                    poll_cnt++;
                end else if (acc_address == 8'hC1) begin
                    c1_cnt++;
                    acc_readdata = res_val[res_idx % 4];
                    res_idx++;
                    poll_cnt = 0;
                end else begin
                    extra_cnt++;
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic prep_layer(input int nn, input logic [31:0] wb, input logic [31:0] ib,
                              input logic [31:0] rb, input logic rl, input logic [31:0] ival);
        logic [31:0] a;
        logic [31:0] r;
        exp_rd_addr.delete(); exp_acc_wr.delete(); exp_mem_wr.delete();
        done_cnt = 0; d9_cnt = 0; c1_cnt = 0; res_idx = 0; poll_cnt = 0;
        extra_cnt = 0; stall_viol = 0; strobe_viol = 0; acc_wr_cnt = 0;
        for (int i = 0; i < VL; i++) mem[ib + 32'(i * 4)] = ival;
        for (int k = 0; k < nn; k++) begin
            for (int i = 0; i < VL; i++) begin
                a = wb + 32'((k * VL + i) * 4);
                mem[a] = wv[k];
                exp_rd_addr.push_back(a);
                exp_acc_wr.push_back({8'h01 + 8'(i), wv[k]});
            end
            for (int i = 0; i < VL; i++) begin
                exp_rd_addr.push_back(ib + 32'(i * 4));
                exp_acc_wr.push_back({8'h61 + 8'(i), ival});
            end
            r = (rl && res_val[k][31]) ? 32'h0 : res_val[k];
            exp_mem_wr.push_back({rb + 32'(k * 4), r});
        end
    endtask

    task automatic launch(input int nn, input logic [31:0] wb, input logic [31:0] ib,
                          input logic [31:0] rb, input logic rl);
        @(negedge clk);
        start = 1'b1; num_neurons = NW'(nn);
        weight_base = wb; image_base = ib; result_base = rb; relu_en = rl;
        @(negedge clk);
        start = 1'b0; num_neurons = 16'd9;
        weight_base = 32'h5000_0000; image_base = 32'h6000_0000; result_base = 32'h7000_0000;
        relu_en = ~rl;
        check("busy_run", busy, 1);
    endtask

    task automatic finish_layer(input int nn, input bit dbl);
        int cyc = 0;
        while (done_cnt == 0 && cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
            start = (dbl && cyc == 100);
        end
        start = 1'b0;
        check("layer_timeout", cyc < TIMEOUT, 1);
        repeat (4) @(negedge clk);
        check("done_pulses", done_cnt, 1);
        check("busy_after", busy, 0);
        check("acc_wr_left", exp_acc_wr.size(), 0);
        check("mem_rd_left", exp_rd_addr.size(), 0);
        check("mem_wr_left", exp_mem_wr.size(), 0);
        check("extra_txn", extra_cnt, 0);
        check("poll_reads", d9_cnt, nn * (poll_hold + 1));
        check("result_reads", c1_cnt, nn);
        check("strobe_excl", strobe_viol, 0);
        check("stall_hold", stall_viol, 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check(tag, {mem_address, mem_writedata}, 64'h0);
        check(tag, {busy, done, mem_read, mem_write, acc_read, acc_write, acc_address, acc_writedata}, 64'h0);
    endtask

    initial begin
        int cyc;
        reset_n = 1'b0; start = 1'b0; num_neurons = '0; relu_en = 1'b0;
        weight_base = '0; image_base = '0; result_base = '0;
        mem_waitrequest = 1'b0; mem_readdata = '0; mem_readdatavalid = 1'b0; acc_readdata = '0;
        stall_en = 1'b0; poll_hold = 1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_state");
        reset_n = 1'b1;

        // nominal single neuron: 96 * 1.0 * 2.0 = 192.0
        stall_en = 1'b0; poll_hold = 1;
        wv[0] = 32'h3F800000; res_val[0] = 32'h43400000;
        prep_layer(1, 32'h0000_1000, 32'h0000_8000, 32'h0000_9000, 1'b0, 32'h40000000);
        launch(1, 32'h0000_1000, 32'h0000_8000, 32'h0000_9000, 1'b0);
        finish_layer(1, 1'b0);

        // three neurons under stalls, with a stray start while busy
        stall_en = 1'b1; poll_hold = 2;
        wv[0] = 32'h3F800000; wv[1] = 32'h40000000; wv[2] = 32'h40400000;
        res_val[0] = 32'h42C00000; res_val[1] = 32'h43400000; res_val[2] = 32'h43900000;
        prep_layer(3, 32'h0002_0000, 32'h0001_0000, 32'h0003_0000, 1'b0, 32'h3F800000);
        launch(3, 32'h0002_0000, 32'h0001_0000, 32'h0003_0000, 1'b0);
        finish_layer(3, 1'b1);

        // ReLU on: -96.0 and -0.0 clamp to +0.0, positive passes
        poll_hold = 0;
        wv[0] = 32'hBF800000; wv[1] = 32'hBF800000; wv[2] = 32'hBF800000;
        res_val[0] = 32'hC2C00000; res_val[1] = 32'h80000000; res_val[2] = 32'h42C00000;
        prep_layer(3, 32'h0004_0000, 32'h0005_0000, 32'h0006_0000, 1'b1, 32'h3F800000);
        launch(3, 32'h0004_0000, 32'h0005_0000, 32'h0006_0000, 1'b1);
        finish_layer(3, 1'b0);

        // ReLU off, weight and result addresses wrap past 2^32
        prep_layer(2, 32'hFFFF_FF00, 32'h0000_4000, 32'hFFFF_FFFC, 1'b0, 32'h3F800000);
        launch(2, 32'hFFFF_FF00, 32'h0000_4000, 32'hFFFF_FFFC, 1'b0);
        finish_layer(2, 1'b0);

        // status flag stays low for five polls
        stall_en = 1'b0; poll_hold = 5;
        wv[0] = 32'h3F800000; res_val[0] = 32'h42C00000;
        prep_layer(1, 32'h0000_1000, 32'h0000_8000, 32'h0000_9000, 1'b0, 32'h3F800000);
        launch(1, 32'h0000_1000, 32'h0000_8000, 32'h0000_9000, 1'b0);
        finish_layer(1, 1'b0);

        // zero neurons, start held into the busy window
        poll_hold = 1;
        prep_layer(0, 32'h0, 32'h0000_8000, 32'h0, 1'b0, 32'h0);
        exp_rd_addr.delete();
        @(negedge clk);
        start = 1'b1; num_neurons = '0;
        @(negedge clk);
        num_neurons = 16'd2;
        check("zero_busy_t1", busy, 1);
        check("zero_done_t1", done, 0);
        @(negedge clk);
        start = 1'b0;
        check("zero_done_t2", done, 1);
        check("zero_busy_t2", busy, 1);
        @(negedge clk);
        check("zero_done_t3", done, 0);
        check("zero_busy_t3", busy, 0);
        repeat (10) @(negedge clk);
        check("zero_done_cnt", done_cnt, 1);
        check("zero_extra", extra_cnt, 0);
        check("zero_acc_reads", d9_cnt + c1_cnt + acc_wr_cnt, 0);

        // reset during neuron 1 image push, then a clean run
        wv[0] = 32'h3F800000; wv[1] = 32'h40000000;
        res_val[0] = 32'h42C00000; res_val[1] = 32'h43400000;
        prep_layer(2, 32'h0000_1000, 32'h0000_8000, 32'h0000_9000, 1'b0, 32'h3F800000);
        launch(2, 32'h0000_1000, 32'h0000_8000, 32'h0000_9000, 1'b0);
        cyc = 0;
        while (acc_wr_cnt < 300 && cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_reach_push", cyc < TIMEOUT, 1);
        #2 reset_n = 1'b0;
        #1 check_outputs_zero("rst_midrun");
        repeat (3) @(negedge clk);
        check("rst_no_done", done_cnt, 0);
        reset_n = 1'b1;
        wv[0] = 32'h40000000; res_val[0] = 32'h43400000;
        prep_layer(1, 32'h0000_1000, 32'h0000_8000, 32'h0000_A000, 1'b0, 32'h3F800000);
        launch(1, 32'h0000_1000, 32'h0000_8000, 32'h0000_A000, 1'b0);
        finish_layer(1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nn_acc_layer_sequencer.md
Name: nn_acc_layer_sequencer

Overview:
- Avalon-MM master sequencer that sits directly upstream of the single MAC accelerator slave. It drives that slave's 8-bit register map.
- For each neuron of a fully connected layer, it fetches VECTOR_LEN weights, then VECTOR_LEN image words from system memory, and pushes them into the accelerator.
- It then polls the accelerator's result-valid flag, reads the FP32 dot product, optionally applies ReLU, and writes the result back to memory.
- It removes the CPU from the per-word transfer loop.

Parameters:
- VECTOR_LEN, 96, words per weight/image vector; must equal the accelerator buffer depth.
- ADDR_WIDTH, 32, memory byte-address width.
- NEURON_WIDTH, 16, width of the neuron count and neuron index.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle start pulse; sampled only in IDLE
- num_neurons  in  NEURON_WIDTH  neurons to compute
- weight_base  in  ADDR_WIDTH  byte address of neuron 0 weight vector
- image_base  in  ADDR_WIDTH  byte address of image vector
- result_base  in  ADDR_WIDTH  byte address of result array
- relu_en  in  1  clamp negative results to +0.0
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse when the layer completes
- mem_address  out  ADDR_WIDTH  memory master address
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_writedata  out  32  memory write data
- mem_waitrequest  in  1  memory stall
- mem_readdata  in  32  memory read data
- mem_readdatavalid  in  1  memory read data valid
- acc_address  out  8  accelerator register address
- acc_read  out  1  accelerator read strobe
- acc_write  out  1  accelerator write strobe
- acc_writedata  out  32  accelerator write data
- acc_readdata  in  32  accelerator read data, registered, valid 1 cycle after acc_read

Behaviour:
- Reset (async, reset_n=0):
  - All outputs are 0 and the FSM is in IDLE.
  - Word counter i and neuron counter n clear.
  - Asserting reset mid-operation abandons the layer immediately; no done pulse is produced.
- States: IDLE, FETCH_W, WAIT_W, PUSH_W, FETCH_I, WAIT_I, PUSH_I, POLL, POLL_WAIT, RD_RES, RD_WAIT, WR_RES, NEXT, FINISH.
- IDLE:
  - start=1 latches all inputs, sets busy=1 and clears n.
  - If num_neurons==0, go to FINISH; otherwise clear i and go to FETCH_W.
  - start while busy is ignored.
- FETCH_W:
  - Drive mem_read=1, mem_address = weight_base + (n*VECTOR_LEN + i)*4.
  - Hold address and read stable while mem_waitrequest=1.
  - When mem_waitrequest=0, go to WAIT_W. Only one read is outstanding at a time.
- WAIT_W: on mem_readdatavalid, capture mem_readdata, then go to PUSH_W.
- PUSH_W:
  - Single-cycle acc_write=1, acc_address = 8'h01 + i, acc_writedata = captured word.
  - i++. If i reaches VECTOR_LEN, clear i and go to FETCH_I; otherwise go to FETCH_W.
- FETCH_I / WAIT_I / PUSH_I:
  - Same sequence with mem_address = image_base + i*4 and acc_address = 8'h61 + i.
  - The image is re-fetched for every neuron.
  - After the last word, go to POLL.
- POLL: single-cycle acc_read=1, acc_address=8'hD9.
- POLL_WAIT: sample acc_readdata[0]. If 1, go to RD_RES; otherwise go back to POLL.
- RD_RES: single-cycle acc_read=1, acc_address=8'hC1. This read clears the accelerator flag.
- RD_WAIT: capture acc_readdata as R.
- WR_RES:
  - mem_write=1, mem_address = result_base + n*4.
  - mem_writedata = (relu_en && R[31]) ? 32'h0 : R. Both -0.0 and negative values map to +0.0.
  - Hold address, write and data while mem_waitrequest=1.
- NEXT: n++. If n==num_neurons go to FINISH; otherwise clear i and go to FETCH_W.
- FINISH: done=1 for exactly one cycle, busy=0 from the next cycle, then return to IDLE.
- Strobe rules:
  - acc_read and acc_write are never both high.
  - acc_* strobes are never asserted at the same time as mem_read or mem_write.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is not flagged.
- mem_readdatavalid outside WAIT_W/WAIT_I is ignored.

Test Plan:
- Nominal single neuron: num_neurons=1, weights all 1.0 (32'h3F800000), image all 2.0 (32'h40000000), VECTOR_LEN=96 -> 96 weight writes to addresses 0x01..0x60, then 96 image writes to 0x61..0xC0. Exactly one write of 32'h43400000 (192.0) to result_base. done pulses once.
- Multi-neuron with waitrequest: num_neurons=3, neuron k weights = k+1 (1.0, 2.0, 3.0), image 1.0, random 0-3 cycle mem_waitrequest and readdatavalid delay -> results 96.0, 192.0, 288.0 at result_base+0/4/8. Addresses held stable during every stall.
- ReLU: weights -1.0, image 1.0 -> relu_en=1 writes 32'h00000000; relu_en=0 writes 32'hC2C00000 (-96.0).
- Polling: accelerator model holds 0xD9 bit0 low for 5 polls -> exactly 6 POLL reads, then one 0xC1 read.
- num_neurons=0: start -> no mem or acc transactions; done pulses 2 cycles after start. Also drive start while busy -> ignored, with no second layer run.
- Reset mid-run: drop reset_n during neuron 1 image push -> all outputs 0 immediately. A subsequent start runs cleanly from neuron 0.
